// File: rtl/ram_sparc_sync_if.sv
// MFA/MFC memory bus between the SPARC control unit (master) and the data RAM (slave).
// The master holds MFA and the command; the slave raises MFC (with Misaligned) and holds it until MFA drops.
interface ram_sparc_sync_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  MFA;
  logic [5:0]            opcode;
  logic [ADDR_WIDTH-1:0] address;
  logic [63:0]           DataIn;
  logic [63:0]           DataOut;
  logic                  MFC;
  logic                  Misaligned;

  modport master (
    output MFA, opcode, address, DataIn,
    input  DataOut, MFC, Misaligned
  );

  modport slave (
    input  MFA, opcode, address, DataIn,
    output DataOut, MFC, Misaligned
  );
endinterface

// File: rtl/ram_sparc_sync.sv
// Byte-addressable big-endian SPARC data RAM with MFA/MFC handshake, wait states,
// doubleword (ldd/std) support in two beats and misalignment reporting.
module ram_sparc_sync #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  ram_sparc_sync_if.slave  bus,
  output logic [2:0]       state_dbg
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = $clog2(WAIT_CYCLES + 2);

  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;
  localparam logic [5:0] OP_LD   = 6'b001000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDD  = 6'b000011;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STD  = 6'b000111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    ACCESS = 3'd2,
    BEAT2  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [5:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [63:0]           din_q, din_d;
  logic [63:0]           dout_q, dout_d;
  logic                  mfc_q, mfc_d;
  logic                  mis_q, mis_d;

  logic [7:0]            mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_k [8];
  logic [63:0]           rword;
  logic [63:0]           store_val;
  logic [7:0]            wbyte [8];
  logic [7:0]            we;
  logic [63:0]           load_val;
  logic                  is_single_load;
  logic                  is_double;
  logic                  misal;

  // Lane k addresses byte a+k (wrapping modulo DEPTH); lane 0 is the most significant byte.
  always_comb begin
    rword = '0;
    for (int k = 0; k < 8; k++) begin
      addr_k[k]            = addr_q + ADDR_WIDTH'(k);
      rword[63-8*k -: 8]   = mem[addr_k[k]];
    end
  end

  always_comb begin
    misal     = 1'b0;
    is_double = 1'b0;
    case (op_q)
      OP_LDSH, OP_LDUH, OP_STH: misal = addr_q[0];
      OP_LD, OP_ST:             misal = |addr_q[1:0];
      OP_LDD, OP_STD: begin
        misal     = |addr_q[2:0];
        is_double = 1'b1;
      end
      default: misal = 1'b0;
    endcase
  end

  always_comb begin
    load_val       = dout_q;
    is_single_load = 1'b1;
    case (op_q)
      OP_LDSB: load_val = {32'b0, {24{rword[63]}}, rword[63:56]};
      OP_LDSH: load_val = {32'b0, {16{rword[63]}}, rword[63:48]};
      OP_LD:   load_val = {32'b0, rword[63:32]};
      OP_LDUB: load_val = {56'b0, rword[63:56]};
      OP_LDUH: load_val = {48'b0, rword[63:48]};
      default: is_single_load = 1'b0;
    endcase
  end

  // Store data is left-aligned so lane k always takes the k-th byte from the top.
  always_comb begin
    store_val = din_q;
    we        = 8'h00;
    case (op_q)
      OP_STB:  store_val = {din_q[7:0], 56'b0};
      OP_STH:  store_val = {din_q[15:0], 48'b0};
      OP_ST:   store_val = {din_q[31:0], 32'b0};
      default: store_val = din_q;
    endcase
    for (int k = 0; k < 8; k++) wbyte[k] = store_val[63-8*k -: 8];
    if (!misal) begin
      if (state == ACCESS) begin
        case (op_q)
          OP_STB:        we = 8'h01;
          OP_STH:        we = 8'h03;
          OP_ST, OP_STD: we = 8'h0F;
          default:       we = 8'h00;
        endcase
      end else if (state == BEAT2 && op_q == OP_STD) begin
        we = 8'hF0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (we[k]) mem[addr_k[k]] <= wbyte[k];
    end
  end

  // Handshake: MFA is a level request sampled in IDLE; MFC (qualified by Misaligned) rises when
  // the access is done and stays high until MFA is seen low, so a held MFA never restarts.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    op_d    = op_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dout_d  = dout_q;
    mfc_d   = mfc_q;
    mis_d   = mis_q;
    unique case (state)
      IDLE: begin
        if (bus.MFA) begin
          op_d    = bus.opcode;
          addr_d  = bus.address;
          din_d   = bus.DataIn;
          cnt_d   = CW'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt - CW'(1);
        if (cnt == CW'(1)) state_d = ACCESS;
      end
      ACCESS: begin
        if (is_double) begin
          state_d = BEAT2;
        end else begin
          state_d = DONE;
          mfc_d   = 1'b1;
          mis_d   = misal;
          if (!misal && is_single_load) dout_d = load_val;
        end
      end
      BEAT2: begin
        state_d = DONE;
        mfc_d   = 1'b1;
        mis_d   = misal;
        if (!misal && op_q == OP_LDD) dout_d = rword;
      end
      DONE: begin
        if (!bus.MFA) begin
          state_d = IDLE;
          mfc_d   = 1'b0;
          mis_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      addr_q <= '0;
      din_q  <= '0;
      dout_q <= '0;
      mfc_q  <= 1'b0;
      mis_q  <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      op_q   <= op_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      dout_q <= dout_d;
      mfc_q  <= mfc_d;
      mis_q  <= mis_d;
    end
  end

  assign bus.DataOut    = dout_q;
  assign bus.MFC        = mfc_q;
  assign bus.Misaligned = mis_q;
  assign state_dbg      = state;
endmodule

// File: tb/tb_ram_sparc_sync.sv
// Directed bench for ram_sparc_sync: loads/stores, ldd/std, alignment, handshake and reset cases.
module tb_ram_sparc_sync;
  localparam int AW = 8;
  localparam int WC = 2;

  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;
  localparam logic [5:0] OP_LD   = 6'b001000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDD  = 6'b000011;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STD  = 6'b000111;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_BEAT2 = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ram_sparc_sync_if #(.ADDR_WIDTH(AW)) bus ();
  logic [2:0] state_dbg;

  ram_sparc_sync #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] last_dout;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full access: request at a negedge, scramble inputs after edge 0, measure MFC edge, release MFA.
  task automatic run(input string tag, input logic [5:0] op, input logic [7:0] a,
                     input logic [63:0] d, input int exp_lat, input logic exp_mis);
    int lat;
    @(negedge clk);
    bus.MFA = 1'b1; bus.opcode = op; bus.address = a; bus.DataIn = d;
    @(posedge clk);
    @(negedge clk);
    bus.opcode  = 6'($urandom_range(0, 63));
    bus.address = 8'($urandom_range(0, 255));
    bus.DataIn  = {$urandom, $urandom};
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (bus.MFC) break;
    end
    check({tag, " lat"}, 64'(lat), 64'(exp_lat));
    check({tag, " mis"}, 64'(bus.Misaligned), 64'(exp_mis));
    last_dout = bus.DataOut;
    @(negedge clk);
    bus.MFA = 1'b0;
    @(posedge clk); #1;
    check({tag, " mfc_clr"}, 64'(bus.MFC), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.MFA = 1'b0; bus.opcode = '0; bus.address = '0; bus.DataIn = '0;
    repeat (2) @(posedge clk); #1;
    check("rst dout", bus.DataOut, 64'd0);
    check("rst mfc", 64'(bus.MFC), 64'd0);
    check("rst mis", 64'(bus.Misaligned), 64'd0);
    check("rst state", 64'(state_dbg), 64'(ST_IDLE));
    @(negedge clk) reset_n = 1'b1;

    // Word, byte and sign-extended byte
    run("st10", OP_ST, 8'h10, 64'h0000_0000_DEAD_BEEF, 3, 1'b0);
    run("ld10", OP_LD, 8'h10, 64'h0, 3, 1'b0);
    check("ld10 data", last_dout, 64'h0000_0000_DEAD_BEEF);
    run("ldub11", OP_LDUB, 8'h11, 64'h0, 3, 1'b0);
    check("ldub11 data", last_dout, 64'h0000_0000_0000_00AD);
    run("ldsb10", OP_LDSB, 8'h10, 64'h0, 3, 1'b0);
    check("ldsb10 data", last_dout, 64'h0000_0000_FFFF_FFDE);

    // Halfwords over a known word
    run("st20", OP_ST, 8'h20, 64'h0000_0000_1234_5678, 3, 1'b0);
    run("sth20", OP_STH, 8'h20, 64'h0000_0000_0000_80F1, 3, 1'b0);
    run("ldsh20", OP_LDSH, 8'h20, 64'h0, 3, 1'b0);
    check("ldsh20 data", last_dout, 64'h0000_0000_FFFF_80F1);
    run("lduh20", OP_LDUH, 8'h20, 64'h0, 3, 1'b0);
    check("lduh20 data", last_dout, 64'h0000_0000_0000_80F1);
    run("ldub21", OP_LDUB, 8'h21, 64'h0, 3, 1'b0);
    check("ldub21 data", last_dout, 64'h0000_0000_0000_00F1);

    // Doubleword
    run("std40", OP_STD, 8'h40, 64'h0123_4567_89AB_CDEF, 4, 1'b0);
    run("ldd40", OP_LDD, 8'h40, 64'h0, 4, 1'b0);
    check("ldd40 data", last_dout, 64'h0123_4567_89AB_CDEF);
    run("ld44", OP_LD, 8'h44, 64'h0, 3, 1'b0);
    check("ld44 data", last_dout, 64'h0000_0000_89AB_CDEF);

    // Misaligned accesses
    run("ld13", OP_LD, 8'h13, 64'h0, 3, 1'b1);
    check("ld13 data", last_dout, 64'h0000_0000_89AB_CDEF);
    run("st22", OP_ST, 8'h22, 64'h0000_0000_FFFF_FFFF, 3, 1'b1);
    run("ld20", OP_LD, 8'h20, 64'h0, 3, 1'b0);
    check("ld20 data", last_dout, 64'h0000_0000_80F1_5678);
    run("ldd44", OP_LDD, 8'h44, 64'h0, 4, 1'b1);
    check("ldd44 data", last_dout, 64'h0000_0000_80F1_5678);

    // MFA held high well past completion
    @(negedge clk);
    bus.MFA = 1'b1; bus.opcode = OP_LD; bus.address = 8'h10; bus.DataIn = '0;
    @(posedge clk);
    repeat (3) @(posedge clk); #1;
    check("hold mfc e3", 64'(bus.MFC), 64'd1);
    repeat (7) @(posedge clk); #1;
    check("hold mfc e10", 64'(bus.MFC), 64'd1);
    check("hold state", 64'(state_dbg), 64'(ST_DONE));
    check("hold data", bus.DataOut, 64'h0000_0000_DEAD_BEEF);
    @(negedge clk) bus.MFA = 1'b0;
    @(posedge clk); #1;
    check("hold mfc clr", 64'(bus.MFC), 64'd0);
    check("hold idle", 64'(state_dbg), 64'(ST_IDLE));

    // One-cycle MFA pulse
    @(negedge clk);
    bus.MFA = 1'b1; bus.opcode = OP_LD; bus.address = 8'h44;
    @(posedge clk);
    @(negedge clk) bus.MFA = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("pulse mfc e2", 64'(bus.MFC), 64'd0);
    @(posedge clk); #1;
    check("pulse mfc e3", 64'(bus.MFC), 64'd1);
    check("pulse data", bus.DataOut, 64'h0000_0000_89AB_CDEF);
    @(posedge clk); #1;
    check("pulse mfc e4", 64'(bus.MFC), 64'd0);

    // Reset during WAIT of a store
    run("st30", OP_ST, 8'h30, 64'h0000_0000_CAFE_F00D, 3, 1'b0);
    @(negedge clk);
    bus.MFA = 1'b1; bus.opcode = OP_ST; bus.address = 8'h30; bus.DataIn = 64'h0000_0000_1122_3344;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0; bus.MFA = 1'b0;
    #1;
    check("rstw mfc", 64'(bus.MFC), 64'd0);
    check("rstw dout", bus.DataOut, 64'd0);
    check("rstw state", 64'(state_dbg), 64'(ST_IDLE));
    @(negedge clk) reset_n = 1'b1;
    run("ld30", OP_LD, 8'h30, 64'h0, 3, 1'b0);
    check("ld30 data", last_dout, 64'h0000_0000_CAFE_F00D);

    // Reset during BEAT2 of std: first word committed, second dropped
    @(negedge clk);
    bus.MFA = 1'b1; bus.opcode = OP_STD; bus.address = 8'h40; bus.DataIn = 64'hAAAA_AAAA_BBBB_BBBB;
    @(posedge clk);
    repeat (3) @(posedge clk); #1;
    check("rstb state", 64'(state_dbg), 64'(ST_BEAT2));
    @(negedge clk);
    reset_n = 1'b0; bus.MFA = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    run("ld40b", OP_LD, 8'h40, 64'h0, 3, 1'b0);
    check("ld40b data", last_dout, 64'h0000_0000_AAAA_AAAA);
    run("ld44b", OP_LD, 8'h44, 64'h0, 3, 1'b0);
    check("ld44b data", last_dout, 64'h0000_0000_89AB_CDEF);

    // Unknown opcode: handshake completes, no write, DataOut kept
    run("bad", OP_BAD, 8'h40, 64'hFFFF_FFFF_FFFF_FFFF, 3, 1'b0);
    check("bad data", last_dout, 64'h0000_0000_89AB_CDEF);
    run("ld40c", OP_LD, 8'h40, 64'h0, 3, 1'b0);
    check("ld40c data", last_dout, 64'h0000_0000_AAAA_AAAA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
